// File: rtl/byte_pack_swap_ctrl_pkg.sv
// rtl/byte_pack_swap_ctrl_pkg.sv - shared types, sizes and lane helper for the byte packer
package byte_pack_pkg;

    localparam int BYTE_COUNT_DEF = 4;
    localparam int BYTE_SIZE_DEF  = 8;
    localparam int WORD_W         = BYTE_COUNT_DEF * BYTE_SIZE_DEF;

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_e;

    // Mirror lane index: lane idx of a count-lane word maps to lane count-1-idx.
    function automatic int lane_rev(input int idx, input int count = BYTE_COUNT_DEF);
        return count - 1 - idx;
    endfunction

endpackage

// File: rtl/byte_pack_swap_ctrl_if.sv
// rtl/byte_pack_swap_ctrl_if.sv - byte-in / word-out valid-ready bundle
interface byte_pack_if #(
    parameter int BYTE_COUNT = byte_pack_pkg::BYTE_COUNT_DEF,
    parameter int BYTE_SIZE  = byte_pack_pkg::BYTE_SIZE_DEF
);
    logic [BYTE_SIZE-1:0]            s_data;
    logic                            s_valid;
    logic                            s_last;
    logic                            s_ready;
    logic [BYTE_COUNT*BYTE_SIZE-1:0] m_data;
    logic [BYTE_COUNT-1:0]           m_keep;
    logic                            m_last;
    logic                            m_valid;
    logic                            m_ready;

    // Controller side: consumes bytes, produces words.
    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_keep, m_last, m_valid
    );

    // Environment side: produces bytes, consumes words.
    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_keep, m_last, m_valid
    );
endinterface

// File: rtl/byte_pack_swap_ctrl_endian_word_mux.sv
// rtl/byte_pack_swap_ctrl_endian_word_mux.sv - lane-order reversal or pass-through
module endian_word_mux
    import byte_pack_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
) (
    input  logic                    swap,
    input  logic [LANES*LANE_W-1:0] din,
    output logic [LANES*LANE_W-1:0] dout
);

    genvar j;
    generate
        for (j = 0; j < LANES; j++) begin : g_lane
            assign dout[j*LANE_W +: LANE_W] = swap ? din[lane_rev(j, LANES)*LANE_W +: LANE_W]
                                                   : din[j*LANE_W +: LANE_W];
        end
    endgenerate

endmodule

// File: rtl/byte_pack_swap_ctrl.sv
// rtl/byte_pack_swap_ctrl.sv - packs a byte stream into swapped/unswapped words with keep and last
module byte_pack_swap_ctrl
    import byte_pack_pkg::*;
#(
    parameter int BYTE_COUNT = BYTE_COUNT_DEF,
    parameter int BYTE_SIZE  = BYTE_SIZE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_swap,
    byte_pack_if.slave  bus
);

    localparam int DW    = BYTE_COUNT * BYTE_SIZE;
    localparam int IDX_W = $clog2(BYTE_COUNT);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTE_COUNT - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         acc_data_q, acc_data_d;
    logic [BYTE_COUNT-1:0] acc_keep_q, acc_keep_d;
    logic                  acc_last_q, acc_last_d;
    logic                  acc_swap_q, acc_swap_d;
    logic [DW-1:0]         m_data_q, m_data_d;
    logic [BYTE_COUNT-1:0] m_keep_q, m_keep_d;
    logic                  m_last_q, m_last_d;
    logic                  m_valid_q, m_valid_d;

    logic                  s_ready_w, s_fire, slot_free;
    logic [DW-1:0]         cand_data, mux_data;
    logic [BYTE_COUNT-1:0] cand_keep, mux_keep;
    logic                  cand_last, cand_swap, cand_done;

    assign s_ready_w = (state_q == COLLECT) && !rst;
    assign s_fire    = bus.s_valid && s_ready_w;
    assign slot_free = !m_valid_q || bus.m_ready;

    // Candidate word: accumulator merged with the incoming byte, or the parked word in STALL.
    always_comb begin
        cand_data = acc_data_q;
        cand_keep = acc_keep_q;
        cand_last = acc_last_q;
        cand_swap = acc_swap_q;
        cand_done = 1'b1;
        if (state_q == COLLECT) begin
            cand_data[idx_q*BYTE_SIZE +: BYTE_SIZE] = bus.s_data;
            cand_keep[idx_q] = 1'b1;
            cand_last = bus.s_last;
            if (idx_q == '0) begin
                cand_swap = cfg_swap;
            end
            cand_done = s_fire && ((idx_q == IDX_LAST) || bus.s_last);
        end
    end

    endian_word_mux #(.LANES(BYTE_COUNT), .LANE_W(BYTE_SIZE)) u_data_mux (
        .swap (cand_swap),
        .din  (cand_data),
        .dout (mux_data)
    );

    endian_word_mux #(.LANES(BYTE_COUNT), .LANE_W(1)) u_keep_mux (
        .swap (cand_swap),
        .din  (cand_keep),
        .dout (mux_keep)
    );

    // Next-state: accumulate, hand a finished word to the output register, or park it.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        acc_last_d = acc_last_q;
        acc_swap_d = acc_swap_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_last_d   = m_last_q;
        m_valid_d  = m_valid_q && !bus.m_ready;

        if (cand_done && ((state_q == STALL) || s_fire)) begin
            if (slot_free) begin
                m_data_d   = mux_data;
                m_keep_d   = mux_keep;
                m_last_d   = cand_last;
                m_valid_d  = 1'b1;
                state_d    = COLLECT;
                idx_d      = '0;
                acc_data_d = '0;
                acc_keep_d = '0;
                acc_last_d = 1'b0;
                acc_swap_d = 1'b0;
            end else begin
                state_d    = STALL;
                acc_data_d = cand_data;
                acc_keep_d = cand_keep;
                acc_last_d = cand_last;
                acc_swap_d = cand_swap;
            end
        end else if (s_fire) begin
            acc_data_d = cand_data;
            acc_keep_d = cand_keep;
            acc_swap_d = cand_swap;
            idx_d      = idx_q + 1'b1;
        end
    end

    // State, accumulator and output register; reset drops any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= COLLECT;
            idx_q      <= '0;
            acc_data_q <= '0;
            acc_keep_q <= '0;
            acc_last_q <= 1'b0;
            acc_swap_q <= 1'b0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
            m_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
            acc_last_q <= acc_last_d;
            acc_swap_q <= acc_swap_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_last_q   <= m_last_d;
            m_valid_q  <= m_valid_d;
        end
    end

    assign bus.s_ready = s_ready_w;
    assign bus.m_data  = m_data_q;
    assign bus.m_keep  = m_keep_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_valid = m_valid_q;

endmodule

// File: tb/tb_byte_pack_swap_ctrl.sv
// tb/tb_byte_pack_swap_ctrl.sv - randomized self-checking bench for byte_pack_swap_ctrl
module tb_byte_pack_swap_ctrl;
    import byte_pack_pkg::*;

    localparam int BC = 4;
    localparam int BS = 8;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [BC-1:0]     keep;
        logic              last;
    } word_t;

    logic clk = 1'b0;
    logic rst;
    logic cfg_swap;

    byte_pack_if #(.BYTE_COUNT(BC), .BYTE_SIZE(BS)) bus ();

    byte_pack_swap_ctrl #(.BYTE_COUNT(BC), .BYTE_SIZE(BS)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_swap (cfg_swap),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    int     stall_cycles = 0;
    word_t  exp_q[$];
    word_t  obs_q[$];
    logic [BS-1:0] cur_b[$];
    logic   cur_swap = 1'b0;
    word_t  mw;
    logic   rand_done;

    // Reference model: gathers accepted bytes into words; records words taken downstream.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                cur_b.delete();
            end else begin
                if (bus.s_valid && bus.s_ready) begin
                    if (cur_b.size() == 0) cur_swap = cfg_swap;
                    cur_b.push_back(bus.s_data);
                    if (cur_b.size() == BC || bus.s_last) begin
                        mw = '0;
                        for (int k = 0; k < cur_b.size(); k++) begin
                            int lane;
                            lane = cur_swap ? (BC - 1 - k) : k;
                            mw.data[lane*BS +: BS] = cur_b[k];
                            mw.keep[lane] = 1'b1;
                        end
                        mw.last = bus.s_last;
                        exp_q.push_back(mw);
                        cur_b.delete();
                    end
                end
                if (bus.m_valid && bus.m_ready)
                    obs_q.push_back({bus.m_data, bus.m_keep, bus.m_last});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [BS-1:0] b, input logic last);
        logic ok;
        int   n;
        bus.s_data  = b;
        bus.s_last  = last;
        bus.s_valid = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = bus.s_ready;
            if (!ok) stall_cycles++;
            @(posedge clk);
            #1;
            n++;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_byte_timeout byte=%h not accepted within 50 cycles", b);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        @(negedge clk);
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b want=0", bus.m_valid); end
        checks++; if (bus.m_data !== '0) begin failures++; $display("FAIL reset_m_data got=%h want=0", bus.m_data); end
        checks++; if (bus.m_keep !== '0) begin failures++; $display("FAIL reset_m_keep got=%h want=0", bus.m_keep); end
        checks++; if (bus.m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last got=%b want=0", bus.m_last); end
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got=%b want=0", bus.s_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL post_reset_s_ready got=%b want=1", bus.s_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        cfg_swap = 1'b0;
        bus.m_ready = 1'b1;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        @(negedge clk);
        checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL basic_latency m_valid got=%b want=1", bus.m_valid); end
        checks++; if (bus.m_data !== 32'h44332211) begin failures++; $display("FAIL basic_data got=%h want=44332211", bus.m_data); end
        checks++; if (bus.m_keep !== 4'hF) begin failures++; $display("FAIL basic_keep got=%h want=f", bus.m_keep); end
        checks++; if (bus.m_last !== 1'b0) begin failures++; $display("FAIL basic_last got=%b want=0", bus.m_last); end
        idle(3);
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_swap_back_to_back;
        cfg_swap = 1'b1;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        @(negedge clk);
        checks++; if (bus.m_data !== 32'h11223344) begin failures++; $display("FAIL swap_data got=%h want=11223344", bus.m_data); end
        checks++; if (bus.m_keep !== 4'hF) begin failures++; $display("FAIL swap_keep got=%h want=f", bus.m_keep); end
        idle(3);
        exp_q.delete(); obs_q.delete();
        stall_cycles = 0;
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
        idle(3);
        checks++; if (stall_cycles !== 0) begin failures++; $display("FAIL b2b_s_ready stall_cycles got=%0d want=0", stall_cycles); end
        checks++; if (obs_q.size() !== 2 || exp_q.size() !== 2) begin failures++; $display("FAIL b2b_count got=%0d want=%0d (2)", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_word%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_partial;
        logic [31:0] wd;
        logic [3:0]  wk;
        for (int sw = 0; sw < 2; sw++) begin
            cfg_swap = sw[0];
            send_byte(8'hAA, 1'b0);
            send_byte(8'hBB, 1'b1);
            wd = sw[0] ? 32'hAABB0000 : 32'h0000BBAA;
            wk = sw[0] ? 4'hC : 4'h3;
            @(negedge clk);
            checks++; if (bus.m_data !== wd) begin failures++; $display("FAIL partial_data swap=%0d got=%h want=%h", sw, bus.m_data, wd); end
            checks++; if (bus.m_keep !== wk) begin failures++; $display("FAIL partial_keep swap=%0d got=%h want=%h", sw, bus.m_keep, wk); end
            checks++; if (bus.m_last !== 1'b1) begin failures++; $display("FAIL partial_last swap=%0d got=%b want=1", sw, bus.m_last); end
            idle(2);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_stall;
        logic [BS-1:0] b[8];
        logic [31:0]   w1, w2;
        cfg_swap = 1'b0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        w1 = {b[3], b[2], b[1], b[0]};
        w2 = {b[7], b[6], b[5], b[4]};
        for (int i = 0; i < 8; i++) send_byte(b[i], 1'b0);
        @(negedge clk);
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL stall_s_ready got=%b want=0", bus.s_ready); end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== w1) begin
                failures++; $display("FAIL stall_hold cyc=%0d got=%b/%h want=1/%h", c, bus.m_valid, bus.m_data, w1);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        idle(4);
        checks++; if (obs_q.size() !== 2) begin failures++; $display("FAIL stall_count got=%0d want=2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            checks++; if (obs_q[0].data !== w1) begin failures++; $display("FAIL stall_word1 got=%h want=%h", obs_q[0].data, w1); end
            checks++; if (obs_q[1].data !== w2) begin failures++; $display("FAIL stall_word2 got=%h want=%h", obs_q[1].data, w2); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_swap_mid_word;
        logic [BS-1:0] b[8];
        logic [31:0]   w1, w2;
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        w1 = {b[3], b[2], b[1], b[0]};
        w2 = {b[4], b[5], b[6], b[7]};
        cfg_swap = 1'b0;
        send_byte(b[0], 1'b0);
        cfg_swap = 1'b1;
        for (int i = 1; i < 8; i++) send_byte(b[i], 1'b0);
        idle(3);
        checks++; if (obs_q.size() !== 2) begin failures++; $display("FAIL swapmid_count got=%0d want=2", obs_q.size()); end
        if (obs_q.size() == 2) begin
            checks++; if (obs_q[0].data !== w1) begin failures++; $display("FAIL swapmid_word1 got=%h want=%h", obs_q[0].data, w1); end
            checks++; if (obs_q[1].data !== w2) begin failures++; $display("FAIL swapmid_word2 got=%h want=%h", obs_q[1].data, w2); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_word;
        logic [BS-1:0] b[4];
        cfg_swap = 1'b0;
        send_byte(8'h5A, 1'b0);
        send_byte(8'hA5, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== '0 || bus.m_keep !== '0 || bus.m_last !== 1'b0 || bus.s_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_outputs got v=%b d=%h k=%h l=%b r=%b want all 0",
                     bus.m_valid, bus.m_data, bus.m_keep, bus.m_last, bus.s_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) send_byte(b[i], 1'b0);
        idle(3);
        checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL rstmid_count got=%0d want=1", obs_q.size()); end
        if (obs_q.size() == 1) begin
            checks++;
            if (obs_q[0] !== {b[3], b[2], b[1], b[0], 4'hF, 1'b0}) begin
                failures++; $display("FAIL rstmid_word got=%h want=%h", obs_q[0], {b[3], b[2], b[1], b[0], 4'hF, 1'b0});
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    cfg_swap = 1'($urandom_range(0, 1));
                    send_byte(8'($urandom), (i == 79) || ($urandom_range(0, 4) == 0));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    bus.m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.m_ready = 1'b1;
        idle(6);
        checks++; if (obs_q.size() !== exp_q.size() || obs_q.size() == 0) begin failures++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_word%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        cfg_swap    = 1'b0;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        test_reset();
        test_basic();
        test_swap_back_to_back();
        test_partial();
        test_stall();
        test_swap_mid_word();
        test_reset_mid_word();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
